shared_mem: RTL and testbench

- Multi-port shared word memory for the SIMD multiprocessor.
- PORT_COUNT processor ports request reads or writes of up to BUS_SIZE/UNIT_SIZE consecutive UNIT_SIZE-bit words.
- A fixed-priority arbiter grants one read and/or one write per cycle.
- Storage lives in an internal submodule instance u_mem holding array r_mem[0:MEM_SIZE-1] of UNIT_SIZE-bit words; benches may preload it hierarchically.

---
 rtl/shared_mem.sv | 152 +++++++++++++++
 tb/tb_shared_mem.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/shared_mem.sv
// shared_mem: multi-port shared word memory for the SIMD multiprocessor.
// Each processor port may request a read and/or a write of up to NW
// consecutive UNIT_SIZE-bit words starting at a word address. A fixed-priority
// arbiter (lowest port index wins) grants one read and one write per cycle,
// independently.
//
// Ports (top shared_mem):
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset (grants and read data only)
//   i_req_rd     per-port read request
//   i_req_wr     per-port write request
//   i_proc_wr    per-port write data, word 0 at the MSB end
//   i_wr_size    per-port write word count (0..7, clamped to NW)
//   i_proc_addr  per-port start word address (shared by read and write)
//   o_grant_rd   registered one-hot read grant
//   o_grant_wr   registered one-hot write grant
//   o_proc_rd    registered read data, word 0 at the MSB end

// Storage: asynchronous NW-word read port, synchronous NW-word write port.
// Words falling past the end of the array are dropped on write and read as 0.
module shared_mem_store #(
  parameter int MEM_SIZE  = 20,
  parameter int UNIT_SIZE = 32,
  parameter int ADDR_SIZE = 24,
  parameter int BUS_SIZE  = 160
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [ADDR_SIZE-1:0] i_wr_addr,
  input  logic [2:0]           i_wr_size,
  input  logic [BUS_SIZE-1:0]  i_wr_data,
  input  logic [ADDR_SIZE-1:0] i_rd_addr,
  output logic [BUS_SIZE-1:0]  o_rd_data
);
  localparam int NW = BUS_SIZE / UNIT_SIZE;
  localparam int MW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  logic [UNIT_SIZE-1:0] r_mem [0:MEM_SIZE-1];

  // Full-width word addresses keep the range check exact; only the low MW
  // bits index the array, and only after the range check has passed.
  logic [31:0]   wr_idx [NW];
  logic [31:0]   rd_idx [NW];
  logic [NW-1:0] wr_ok;
  logic [NW-1:0] rd_ok;

  for (genvar j = 0; j < NW; j++) begin : g_word
    assign wr_idx[j] = 32'(i_wr_addr) + 32'(j);
    assign rd_idx[j] = 32'(i_rd_addr) + 32'(j);
    // Word j is written only if it lies within the requested count
    // (the loop bound already clamps the count to NW).
    assign wr_ok[j]  = (32'(i_wr_size) > 32'(j)) && (wr_idx[j] < 32'(MEM_SIZE));
    assign rd_ok[j]  = rd_idx[j] < 32'(MEM_SIZE);
    assign o_rd_data[BUS_SIZE-1-j*UNIT_SIZE -: UNIT_SIZE] =
      rd_ok[j] ? r_mem[rd_idx[j][MW-1:0]] : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int j = 0; j < NW; j++) begin
        if (wr_ok[j]) begin
          r_mem[wr_idx[j][MW-1:0]] <= i_wr_data[BUS_SIZE-1-j*UNIT_SIZE -: UNIT_SIZE];
        end
      end
    end
  end
endmodule

module shared_mem #(
  parameter int PORT_COUNT = 4,
  parameter int BUS_SIZE   = 160,
  parameter int MEM_SIZE   = 20,
  parameter int UNIT_SIZE  = 32,
  parameter int ADDR_SIZE  = 24
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [PORT_COUNT-1:0] i_req_rd,
  input  logic [PORT_COUNT-1:0] i_req_wr,
  input  logic [BUS_SIZE-1:0]   i_proc_wr   [PORT_COUNT],
  input  logic [2:0]            i_wr_size   [PORT_COUNT],
  input  logic [ADDR_SIZE-1:0]  i_proc_addr [PORT_COUNT],
  output logic [PORT_COUNT-1:0] o_grant_rd,
  output logic [PORT_COUNT-1:0] o_grant_wr,
  output logic [BUS_SIZE-1:0]   o_proc_rd
);
  localparam int PW = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;

  logic [PW-1:0]         rd_sel, wr_sel;
  logic                  rd_hit, wr_hit;
  logic [PORT_COUNT-1:0] grant_rd_d, grant_rd_q;
  logic [PORT_COUNT-1:0] grant_wr_d, grant_wr_q;
  logic [BUS_SIZE-1:0]   proc_rd_q;
  logic [BUS_SIZE-1:0]   mem_rd_data;

  // Fixed priority: scan from the highest index down so the lowest-index
  // requester is the last assignment and therefore wins.
  always_comb begin
    rd_hit     = 1'b0;
    wr_hit     = 1'b0;
    rd_sel     = '0;
    wr_sel     = '0;
    grant_rd_d = '0;
    grant_wr_d = '0;
    for (int k = PORT_COUNT - 1; k >= 0; k--) begin
      if (i_req_rd[k]) begin
        rd_hit = 1'b1;
        rd_sel = PW'(k);
      end
      if (i_req_wr[k]) begin
        wr_hit = 1'b1;
        wr_sel = PW'(k);
      end
    end
    if (rd_hit) grant_rd_d[rd_sel] = 1'b1;
    if (wr_hit) grant_wr_d[wr_sel] = 1'b1;
  end

  // Read data comes from the pre-edge array contents, so a same-cycle write
  // to the same words is not visible until the following read.
  shared_mem_store #(
    .MEM_SIZE  (MEM_SIZE),
    .UNIT_SIZE (UNIT_SIZE),
    .ADDR_SIZE (ADDR_SIZE),
    .BUS_SIZE  (BUS_SIZE)
  ) u_mem (
    .i_clk     (i_clk),
    .i_we      (wr_hit && !i_rst),
    .i_wr_addr (i_proc_addr[wr_sel]),
    .i_wr_size (i_wr_size[wr_sel]),
    .i_wr_data (i_proc_wr[wr_sel]),
    .i_rd_addr (i_proc_addr[rd_sel]),
    .o_rd_data (mem_rd_data)
  );

  // Output register stage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      grant_rd_q <= '0;
      grant_wr_q <= '0;
      proc_rd_q  <= '0;
    end else begin
      grant_rd_q <= grant_rd_d;
      grant_wr_q <= grant_wr_d;
      if (rd_hit) proc_rd_q <= mem_rd_data;
    end
  end

  assign o_grant_rd = grant_rd_q;
  assign o_grant_wr = grant_wr_q;
  assign o_proc_rd  = proc_rd_q;
endmodule

// File: tb/tb_shared_mem.sv
// Bench for shared_mem: directed steps followed by random traffic, checked
// against a word-array reference model of the shared memory.
module tb_shared_mem;
  localparam int P  = 4;
  localparam int NW = 5;
  localparam int MS = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic [P-1:0]  req_rd, req_wr;
  logic [159:0]  proc_wr   [P];
  logic [2:0]    wr_size   [P];
  logic [23:0]   proc_addr [P];
  logic [P-1:0]  grant_rd, grant_wr;
  logic [159:0]  proc_rd;

  logic [31:0]   mm [MS];
  logic [159:0]  exp_rd = '0;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  shared_mem dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_rd    (req_rd),
    .i_req_wr    (req_wr),
    .i_proc_wr   (proc_wr),
    .i_wr_size   (wr_size),
    .i_proc_addr (proc_addr),
    .o_grant_rd  (grant_rd),
    .o_grant_wr  (grant_wr),
    .o_proc_rd   (proc_rd)
  );

  function automatic logic [159:0] pack5(input logic [31:0] a, b, c, d, e);
    return {a, b, c, d, e};
  endfunction

  function automatic int lowest(input logic [P-1:0] r);
    for (int i = 0; i < P; i++) if (r[i]) return i;
    return -1;
  endfunction

  function automatic logic [159:0] model_read(input int addr);
    logic [159:0] r = '0;
    for (int j = 0; j < NW; j++) r = (r << 32) | ((addr + j < MS) ? 160'(mm[addr + j]) : 160'd0);
    return r;
  endfunction

  task automatic model_write(input int k);
    int n = (int'(wr_size[k]) < NW) ? int'(wr_size[k]) : NW;
    int a = int'(proc_addr[k]);
    for (int j = 0; j < n; j++)
      if (a + j < MS) mm[a + j] = proc_wr[k][159 - 32 * j -: 32];
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
      $error("%s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock edge: predict from current inputs and model, then compare.
  task automatic tick();
    logic [P-1:0] egr = '0, egw = '0;
    int kr = lowest(req_rd);
    int kw = lowest(req_wr);
    if (rst) begin
      exp_rd = '0;
    end else begin
      if (kr >= 0) begin
        egr[kr] = 1'b1;
        exp_rd  = model_read(int'(proc_addr[kr]));
      end
      if (kw >= 0) egw[kw] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("grant_rd", 160'(grant_rd), 160'(egr));
    chk("grant_wr", 160'(grant_wr), 160'(egw));
    chk("proc_rd", proc_rd, exp_rd);
    if (!rst && kw >= 0) model_write(kw);
  endtask

  task automatic chk_mem(input string tag);
    for (int i = 0; i < MS; i++) chk(tag, 160'(dut.u_mem.r_mem[i]), 160'(mm[i]));
  endtask

  initial begin
    logic [31:0] step2_exp [MS];
    rst    = 1'b1;
    req_rd = '0;
    req_wr = '0;
    for (int k = 0; k < P; k++) begin
      proc_wr[k]   = '0;
      wr_size[k]   = '0;
      proc_addr[k] = '0;
    end
    for (int i = 0; i < MS; i++) begin
      dut.u_mem.r_mem[i] = 32'(i);
      mm[i] = 32'(i);
    end

    // 1: reset clears outputs, keeps memory
    tick();
    chk("rst_grant_rd", 160'(grant_rd), 160'd0);
    chk("rst_proc_rd", proc_rd, 160'd0);
    chk_mem("rst_mem");
    rst = 1'b0;

    // 2: all ports write, lowest index first
    proc_wr[3] = pack5(3, 3, 3, 0, 0); wr_size[3] = 3; proc_addr[3] = 0;
    proc_wr[2] = pack5(2, 2, 2, 2, 0); wr_size[2] = 4; proc_addr[2] = 3;
    proc_wr[1] = pack5(1, 1, 1, 1, 1); wr_size[1] = 5; proc_addr[1] = 7;
    proc_wr[0] = pack5(0, 0, 0, 0, 0); wr_size[0] = 1; proc_addr[0] = 12;
    req_wr = 4'hF; tick(); chk("wr_seq0", 160'(grant_wr), 160'b0001);
    req_wr = 4'hE; tick(); chk("wr_seq1", 160'(grant_wr), 160'b0010);
    req_wr = 4'hC; tick(); chk("wr_seq2", 160'(grant_wr), 160'b0100);
    req_wr = 4'h8; tick(); chk("wr_seq3", 160'(grant_wr), 160'b1000);
    req_wr = 4'h0; tick(); chk("wr_seq4", 160'(grant_wr), 160'b0000);
    for (int i = 0; i < MS; i++)
      step2_exp[i] = (i <= 2) ? 3 : (i <= 6) ? 2 : (i <= 11) ? 1 : (i == 12) ? 0 : 32'(i);
    for (int i = 0; i < MS; i++) chk("step2_mem", 160'(dut.u_mem.r_mem[i]), 160'(step2_exp[i]));

    // 3: reads, lowest index first
    req_rd = 4'hF; tick(); chk("rd_p0", proc_rd, pack5(0, 13, 14, 15, 16));
    chk("rd_gr0", 160'(grant_rd), 160'b0001);
    req_rd = 4'hE; tick(); chk("rd_gr1", 160'(grant_rd), 160'b0010);
    req_rd = 4'hC; tick(); chk("rd_gr2", 160'(grant_rd), 160'b0100);
    req_rd = 4'h8; tick(); chk("rd_p3", proc_rd, pack5(3, 3, 3, 2, 2));
    chk("rd_gr3", 160'(grant_rd), 160'b1000);
    req_rd = 4'h0; tick(); chk("rd_hold", proc_rd, pack5(3, 3, 3, 2, 2));

    // 4: write at end of memory, no wrap
    proc_wr[1] = pack5(32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4); wr_size[1] = 5; proc_addr[1] = 18;
    req_wr = 4'h2; tick();
    req_wr = 4'h0; req_rd = 4'h2; tick();
    chk("edge_rd", proc_rd, pack5(32'hA0, 32'hA1, 0, 0, 0));
    chk("edge_m0", 160'(dut.u_mem.r_mem[0]), 160'd3);
    chk("edge_m17", 160'(dut.u_mem.r_mem[17]), 160'd17);

    // 5: same-cycle read and write, same port and address
    proc_wr[0] = pack5(77, 88, 88, 88, 88); wr_size[0] = 1; proc_addr[0] = 5;
    req_rd = 4'h1; req_wr = 4'h1; tick();
    chk("rw_grants", 160'({grant_rd, grant_wr}), 160'b0001_0001);
    chk("rw_old", proc_rd, pack5(2, 2, 1, 1, 1));
    req_wr = 4'h0; tick();
    chk("rw_new", proc_rd, pack5(77, 2, 1, 1, 1));

    // 6: reset with requests active
    proc_wr[0] = pack5(99, 99, 99, 99, 99); wr_size[0] = 5; proc_addr[0] = 0;
    rst = 1'b1; req_rd = 4'hF; req_wr = 4'hF; tick();
    chk("rst_mid_gw", 160'(grant_wr), 160'd0);
    chk("rst_mid_m0", 160'(dut.u_mem.r_mem[0]), 160'd3);
    rst = 1'b0; req_rd = '0; req_wr = '0; tick();
    chk_mem("rst_mid_mem");

    // Random traffic
    for (int c = 0; c < 300; c++) begin
      rst    = ($urandom_range(0, 39) == 0);
      req_rd = 4'($urandom);
      req_wr = 4'($urandom);
      for (int k = 0; k < P; k++) begin
        proc_wr[k]   = {$urandom, $urandom, $urandom, $urandom, $urandom};
        wr_size[k]   = 3'($urandom);
        proc_addr[k] = 24'($urandom_range(0, 24));
      end
      tick();
    end
    rst = 1'b0; req_rd = '0; req_wr = '0; tick();
    chk_mem("rand_mem");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
